// File: rtl/img_spawn_if.sv
// Handshake bundle between the spawn queue and the game logic that consumes images.
// The master side drives enable, random index and pop; the queue is the slave.
interface img_spawn_if #(
   parameter int DEPTH = 4
);
   logic                    en;
   logic [1:0]              rand_num;
   logic                    pop;
   logic                    img_valid;
   logic [1:0]              img_idx;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic [7:0]              drop_cnt;

   modport master (
      output en, rand_num, pop,
      input  img_valid, img_idx, count, full, drop_cnt
   );

   modport slave (
      input  en, rand_num, pop,
      output img_valid, img_idx, count, full, drop_cnt
   );
endinterface

// File: rtl/img_spawn_queue.sv
// Samples the random image index once per spawn period, retries illegal codes,
// limits repeated images and buffers accepted indices in a small FIFO.
module img_spawn_queue #(
   parameter int PERIOD  = 50_000_000,
   parameter int DEPTH   = 4,
   parameter int MAX_RUN = 2
) (
   input  logic       clk,
   input  logic       rst,
   img_spawn_if.slave bus
);
   localparam int TW = $clog2(PERIOD);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(MAX_RUN + 1);

   typedef enum logic {S_IDLE, S_RETRY} state_t;

   state_t          state_reg, state_next;
   logic [TW-1:0]   tick_reg;
   logic [1:0]      last_reg;
   logic [RW-1:0]   run_reg;
   logic [1:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     count_reg, count_next;
   logic            valid_reg, full_reg;
   logic [7:0]      drop_reg;

   logic            tick, legal, attempt, accept;
   logic            do_pop, do_push, do_drop;
   logic [1:0]      gen;

   assign tick  = bus.en && (tick_reg == TW'(PERIOD - 1));
   assign legal = (bus.rand_num != 2'd3);

   // S_RETRY holds the single outstanding attempt; ticks landing there are absorbed.
   always_comb begin
      state_next = state_reg;
      attempt    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (tick) begin
               attempt = 1'b1;
               if (!legal) state_next = S_RETRY;
            end
         end
         S_RETRY: begin
            if (bus.en) begin
               attempt = 1'b1;
               if (legal) state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   assign accept = attempt && legal;

   // Force a different image once the same one has been generated MAX_RUN times in a row.
   assign gen = (bus.rand_num == last_reg && run_reg == RW'(MAX_RUN)) ?
                ((bus.rand_num == 2'd2) ? 2'd0 : bus.rand_num + 2'd1) :
                bus.rand_num;

   assign do_pop  = bus.pop && valid_reg;
   assign do_push = accept && (!full_reg || do_pop);
   assign do_drop = accept && full_reg && !do_pop;

   always_comb begin
      count_next = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_reg <= '0;
      end else if (bus.en) begin
         tick_reg <= (tick_reg == TW'(PERIOD - 1)) ? '0 : tick_reg + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg <= 2'd0;
         run_reg  <= '0;
      end else if (accept) begin
         last_reg <= gen;
         if (gen == last_reg)
            run_reg <= (run_reg == RW'(MAX_RUN)) ? run_reg : run_reg + RW'(1);
         else
            run_reg <= RW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= gen;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= 1'b0;
         full_reg   <= 1'b0;
         drop_reg   <= 8'd0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
         valid_reg <= (count_next != '0);
         full_reg  <= (count_next == (AW+1)'(DEPTH));
         if (do_drop && drop_reg != 8'd255) drop_reg <= drop_reg + 8'd1;
      end
   end

   assign bus.img_valid = valid_reg;
   assign bus.img_idx   = valid_reg ? mem[rd_ptr_reg] : 2'd0;
   assign bus.count     = count_reg;
   assign bus.full      = full_reg;
   assign bus.drop_cnt  = drop_reg;
endmodule
